program_memory_loader: RTL and testbench

//  Writer side of the program memory. Receives a byte stream over a valid/ready handshake.

---
 rtl/program_memory_loader.sv | 141 ++++++++++++++
 tb/tb_program_memory_loader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_memory_loader.sv
// Program memory writer: packs a valid/ready byte stream into little-endian 32-bit words
// written from BASE_ADDRESS upward. Optional trailing checksum byte: PROGRAM_LOADER_CHECKSUM_EN.
module program_memory_loader #(
  parameter int unsigned           MEMORY_DEPTH = 32,
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = 32'h00400000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic [DATA_WIDTH-1:0] Word_Count,
  input  logic [7:0]            Byte_In,
  input  logic                  Byte_Valid,
  output logic                  Byte_Ready,
  output logic                  Write_Enable,
  output logic [DATA_WIDTH-1:0] Write_Address,
  output logic [DATA_WIDTH-1:0] Write_Data,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error
);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE
  } state_t;

  localparam logic [DATA_WIDTH-1:0] DEPTH_W = DATA_WIDTH'(MEMORY_DEPTH);

  state_t                state_q, state_d;
  logic [1:0]            byte_idx;
  logic [DATA_WIDTH-1:0] word_cnt;
  logic [DATA_WIDTH-1:0] count_q;
  logic                  byte_acc;
  logic                  start_ok;
  logic                  count_zero;
  logic                  count_over;
  logic                  last_word;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]            checksum;
`endif

  assign byte_acc   = Byte_Valid && Byte_Ready;
  assign start_ok   = Start && (state_q == IDLE || state_q == DONE);
  assign count_zero = (Word_Count == '0);
  assign count_over = (Word_Count > DEPTH_W);
  assign last_word  = ((word_cnt + DATA_WIDTH'(1)) == count_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    Byte_Ready   = 1'b0;
    Write_Enable = 1'b0;
    Busy         = 1'b0;
    Done         = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        Done = (state_q == DONE);
        if (Start) state_d = (count_zero || count_over) ? DONE : RECV;
      end
      RECV: begin
        Byte_Ready = 1'b1;
        Busy       = 1'b1;
        if (byte_acc && byte_idx == 2'd3) state_d = WRITE;
      end
      WRITE: begin
        Write_Enable = 1'b1;
        Busy         = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        state_d = last_word ? CHECK : RECV;
`else
        state_d = last_word ? DONE : RECV;
`endif
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CHECK: begin
        Byte_Ready = 1'b1;
        Busy       = 1'b1;
        if (byte_acc) state_d = DONE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Write_Address <= BASE_ADDRESS;
      Write_Data    <= '0;
      byte_idx      <= '0;
      word_cnt      <= '0;
      count_q       <= '0;
      Error         <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      checksum      <= '0;
`endif
    end else begin
      if (start_ok) begin
        // Rejected counts only update Error; the datapath keeps its previous contents.
        if (count_zero) begin
          Error <= 1'b0;
        end else if (count_over) begin
          Error <= 1'b1;
        end else begin
          count_q       <= Word_Count;
          Error         <= 1'b0;
          Write_Address <= BASE_ADDRESS;
          word_cnt      <= '0;
          byte_idx      <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          checksum      <= '0;
`endif
        end
      end
      if (state_q == RECV && byte_acc) begin
        Write_Data[{byte_idx, 3'b000} +: 8] <= Byte_In;
        byte_idx                            <= byte_idx + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        checksum                            <= checksum + Byte_In;
`endif
      end
      if (state_q == WRITE) begin
        Write_Address <= Write_Address + DATA_WIDTH'(4);
        word_cnt      <= word_cnt + DATA_WIDTH'(1);
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      if (state_q == CHECK && byte_acc) Error <= (Byte_In != checksum);
`endif
    end
  end

endmodule

// File: tb/tb_program_memory_loader.sv
// Self-checking bench for program_memory_loader: directed loads, a byte-count write-timing
// model checked every cycle, and literal expectations on the captured writes.
module tb_program_memory_loader;

  localparam logic [31:0] BASE = 32'h00400000;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [31:0] Word_Count;
  logic [7:0]  Byte_In;
  logic        Byte_Valid;
  logic        Byte_Ready;
  logic        Write_Enable;
  logic [31:0] Write_Address;
  logic [31:0] Write_Data;
  logic        Busy;
  logic        Done;
  logic        Error;

  program_memory_loader #(
    .MEMORY_DEPTH(32),
    .DATA_WIDTH  (32),
    .BASE_ADDRESS(32'h00400000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .Start        (Start),
    .Word_Count   (Word_Count),
    .Byte_In      (Byte_In),
    .Byte_Valid   (Byte_Valid),
    .Byte_Ready   (Byte_Ready),
    .Write_Enable (Write_Enable),
    .Write_Address(Write_Address),
    .Write_Data   (Write_Data),
    .Busy         (Busy),
    .Done         (Done),
    .Error        (Error)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned fails  = 0;
  int unsigned n_acc = 0, base_acc = 0, data_bytes = 0;
  int unsigned exp_wr = 0, exp_rd = 0, n_cap = 0;
  logic        exp_we = 1'b0;
  logic [31:0] exp_addr [64];
  logic [31:0] exp_data [64];
  logic [31:0] cap_addr [64];
  logic [31:0] cap_data [64];
  logic [7:0]  prog [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Model: every 4th accepted program byte must yield exactly one write in the following cycle.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (reset) begin
        n_acc  = 0;
        exp_we = 1'b0;
      end else begin
        chk("we_timing", {31'd0, Write_Enable}, {31'd0, exp_we});
        if (Write_Enable) begin
          chk("ready_in_write", {31'd0, Byte_Ready}, 32'd0);
          if (n_cap < 64) begin
            cap_addr[n_cap] = Write_Address;
            cap_data[n_cap] = Write_Data;
            n_cap++;
          end
          if (exp_rd < exp_wr) begin
            chk("wr_addr", Write_Address, exp_addr[exp_rd]);
            chk("wr_data", Write_Data, exp_data[exp_rd]);
            exp_rd++;
          end else begin
            chk("unexpected_write", {31'd0, Write_Enable}, 32'd0);
          end
        end
        exp_we = 1'b0;
        if (Byte_Valid && Byte_Ready) begin
          n_acc++;
          if ((n_acc - base_acc) <= data_bytes && ((n_acc - base_acc) % 4) == 0) exp_we = 1'b1;
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    bit ok;
    ok         = 1'b0;
    Byte_In    = b;
    Byte_Valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (Byte_Ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("byte_accept_timeout", {31'd0, Byte_Ready}, 32'd1);
    @(posedge clk); #1;
    Byte_Valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_start(input logic [31:0] cnt);
    @(posedge clk); #1;
    Start      = 1'b1;
    Word_Count = cnt;
    @(posedge clk); #1;
    Start      = 1'b0;
  endtask

  task automatic run_load(input int unsigned cnt, input int unsigned gap,
                          input int unsigned nbytes, input logic [7:0] csum_off);
    logic [7:0] sum;
    sum = '0;
    pulse_start(cnt);
    base_acc   = n_acc;
    data_bytes = 4 * cnt;
    chk("busy_after_start", {31'd0, Busy}, 32'd1);
    chk("ready_after_start", {31'd0, Byte_Ready}, 32'd1);
    for (int i = 0; i < int'(nbytes); i++) begin
      if ((i % 4) == 3) begin
        exp_addr[exp_wr] = BASE + 32'(4 * (i / 4));
        exp_data[exp_wr] = {prog[i], prog[i-1], prog[i-2], prog[i-3]};
        exp_wr++;
      end
      sum = sum + prog[i];
      send_byte(prog[i], gap);
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    if (nbytes == 4 * cnt) send_byte(sum + csum_off, gap);
`else
    if (csum_off != 8'd0) sum = sum + csum_off;
`endif
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (Done) break;
    end
    chk("done", {31'd0, Done}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'd0, Byte_Ready}, 32'd0);
    chk({tag, "_we"},    {31'd0, Write_Enable}, 32'd0);
    chk({tag, "_busy"},  {31'd0, Busy}, 32'd0);
    chk({tag, "_done"},  {31'd0, Done}, 32'd0);
    chk({tag, "_error"}, {31'd0, Error}, 32'd0);
    chk({tag, "_addr"},  Write_Address, BASE);
    chk({tag, "_data"},  Write_Data, 32'd0);
  endtask

  task automatic main_seq();
    int unsigned cb;
    reset      = 1'b1;
    Start      = 1'b0;
    Word_Count = '0;
    Byte_In    = '0;
    Byte_Valid = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Two words back-to-back
    prog = '{8'h20, 8'h00, 8'h08, 8'h20, 8'h0A, 8'h00, 8'h09, 8'h24};
    cb = n_cap;
    run_load(2, 0, 8, 8'd0);
    wait_done();
    chk("b2b_error", {31'd0, Error}, 32'd0);
    chk("b2b_busy", {31'd0, Busy}, 32'd0);
    chk("b2b_ready", {31'd0, Byte_Ready}, 32'd0);
    chk("b2b_nwrites", n_cap - cb, 32'd2);
    chk("b2b_w0_data", cap_data[cb], 32'h20080020);
    chk("b2b_w0_addr", cap_addr[cb], 32'h00400000);
    chk("b2b_w1_data", cap_data[cb+1], 32'h2409000A);
    chk("b2b_w1_addr", cap_addr[cb+1], 32'h00400004);

    // Byte_Valid toggling
    cb = n_cap;
    run_load(2, 1, 8, 8'd0);
    wait_done();
    chk("tog_error", {31'd0, Error}, 32'd0);
    chk("tog_nwrites", n_cap - cb, 32'd2);
    chk("tog_w0_data", cap_data[cb], 32'h20080020);
    chk("tog_w1_data", cap_data[cb+1], 32'h2409000A);
    chk("tog_w1_addr", cap_addr[cb+1], 32'h00400004);

    // Oversize count
    cb = n_cap;
    pulse_start(32'd33);
    chk("over_done", {31'd0, Done}, 32'd1);
    chk("over_error", {31'd0, Error}, 32'd1);
    chk("over_busy", {31'd0, Busy}, 32'd0);
    repeat (4) @(negedge clk);
    chk("over_nwrites", n_cap - cb, 32'd0);

    // Zero count
    pulse_start(32'd0);
    chk("zero_done", {31'd0, Done}, 32'd1);
    chk("zero_error", {31'd0, Error}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("zero_ready", {31'd0, Byte_Ready}, 32'd0);
    end
    chk("zero_nwrites", n_cap - cb, 32'd0);

    // Reset after 6 bytes of a 2-word load, then reload
    cb = n_cap;
    run_load(2, 0, 6, 8'd0);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    chk("abort_nwrites", n_cap - cb, 32'd1);
    chk("abort_w0_addr", cap_addr[cb], 32'h00400000);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_more_writes", n_cap - cb, 32'd1);
    cb = n_cap;
    run_load(2, 0, 8, 8'd0);
    wait_done();
    chk("reload_nwrites", n_cap - cb, 32'd2);
    chk("reload_w0_addr", cap_addr[cb], 32'h00400000);
    chk("reload_w0_data", cap_data[cb], 32'h20080020);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    prog = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
    cb = n_cap;
    run_load(1, 0, 4, 8'd0);
    wait_done();
    chk("csum_ok_error", {31'd0, Error}, 32'd0);
    chk("csum_ok_data", cap_data[cb], 32'h04030201);
    cb = n_cap;
    run_load(1, 0, 4, 8'd1);
    wait_done();
    chk("csum_bad_error", {31'd0, Error}, 32'd1);
    chk("csum_bad_nwrites", n_cap - cb, 32'd1);
    chk("csum_bad_data", cap_data[cb], 32'h04030201);
`endif
    repeat (2) @(negedge clk);
  endtask

  initial begin
    fork
      monitor();
      main_seq();
      begin
        #200000;
        checks++;
        fails++;
        $display("FAIL global_timeout: got running expected finished");
      end
    join_any
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
